data_memory: RTL

//   Parametrised RV32 data memory for the load/store stage: LB/LH/LW/LBU/LHU loads and SB/SH/SW stores

---
 rtl/data_memory.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/data_memory.sv
// RV32 data memory for the load/store stage: byte/half/word loads and stores over a
// valid/ready request/response handshake, with a fixed, configurable response latency.
module data_memory #(
  parameter int unsigned MEMSIZE = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask
);

  localparam int unsigned WORDS = MEMSIZE / 4;
  localparam int unsigned AW    = $clog2(MEMSIZE);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [3:0]  rmask_q, rmask_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] mem_q [WORDS];

  logic          accept;
  logic          mem_we;
  logic [1:0]    off;
  logic [AW-3:0] word_idx;
  logic [32:0]   span;
  logic [32:0]   last_byte;
  logic [3:0]    base_lanes;
  logic [3:0]    lanes;
  logic          size_ok;
  logic          misaligned;
  logic          out_of_range;
  logic          fault;
  logic [31:0]   rd_word;
  logic [31:0]   shifted;
  logic [31:0]   load_val;
  logic [31:0]   store_val;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign off       = req_addr[1:0];
  assign word_idx  = req_addr[AW-1:2];

  // Request decode: size, legality, alignment, range, lane mask and load extraction.
  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    span       = 33'd0;
    base_lanes = 4'b0000;
    size_ok    = 1'b1;
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'd0: begin span = 33'd0; base_lanes = 4'b0001; end
      2'd1: begin span = 33'd1; base_lanes = 4'b0011; misaligned = off[0]; end
      2'd2: begin span = 33'd3; base_lanes = 4'b1111; misaligned = (off != 2'd0); end
      default: size_ok = 1'b0;
    endcase
    // Stores only allow funct3 0..2; loads additionally allow the unsigned forms 4 and 5.
    if (req_write) size_ok = size_ok && !req_funct3[2];
    else           size_ok = size_ok && !(req_funct3[2] && req_funct3[1]);

    last_byte    = {1'b0, req_addr} + span;
    out_of_range = (last_byte >= 33'(MEMSIZE));
    fault        = !size_ok || misaligned || out_of_range;
    lanes        = base_lanes << off;

    rd_word = mem_q[word_idx];
    shifted = rd_word >> {off, 3'b000};
    case (req_funct3)
      3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_val = {24'd0, shifted[7:0]};
      3'd5:    load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase

    case (req_funct3[1:0])
      2'd0:    store_val = {4{req_wdata[7:0]}};
      2'd1:    store_val = {2{req_wdata[15:0]}};
      default: store_val = req_wdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    rmask_d = rmask_q;
    wmask_d = wmask_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          fault_d = fault;
          rdata_d = (fault || req_write) ? 32'd0 : load_val;
          rmask_d = (fault || req_write) ? 4'd0 : lanes;
          wmask_d = (fault || !req_write) ? 4'd0 : lanes;
          if (LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = 4'd1;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'(LATENCY - 1)) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
      rmask_q <= 4'd0;
      wmask_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
    end
  end

  assign mem_we = accept && req_write && !fault && !reset;

  // NOTE: the storage array is deliberately not reset; contents survive reset and stay plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) mem_q[word_idx][b*8 +: 8] <= store_val[b*8 +: 8];
      end
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign resp_fault = resp_valid && fault_q;
  assign rmask      = resp_valid ? rmask_q : 4'd0;
  assign wmask      = resp_valid ? wmask_q : 4'd0;

endmodule
